// File: rtl/myproject_accum_pkg.sv
// Shared definitions for the dense-layer accumulator blocks.
//   - Default widths for the 16s x 12s product -> 16-bit activation chain.
//   - state_t: frame FSM states (ACCUM collects beats, OUT holds the result).
//   - OUT_MAX / OUT_MIN: saturation limits of the default output format.
package myproject_accum_pkg;

    localparam int PROD_W     = 28;
    localparam int ACC_W      = 34;
    localparam int OUT_W      = 16;
    localparam int FRAC_SHIFT = 10;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational round-and-saturate stage.
// Converts an ACC_W-bit signed sum at product scale into an OUT_W-bit signed
// value at output scale: round half toward +inf, then clamp to the OUT_W range.
// Ports:
//   sum      in  ACC_W  signed accumulator value
//   data     out OUT_W  rounded, saturated result
//   sat      out 1      result was clamped
module myproject_round_sat #(
    parameter int ACC_W      = 34,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 10
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_SHIFT - 1);

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic        [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;
    logic [ACC_W-OUT_W+1:0] upper;
    logic                   in_range;

    always_comb begin
        rounded = {sum[ACC_W-1], sum} + HALF;
        shifted = $signed(rounded) >>> FRAC_SHIFT;
        // The value fits OUT_W bits exactly when every bit from the OUT_W
        // sign position upward is a copy of the sign.
        upper    = shifted[ACC_W:OUT_W-1];
        in_range = (&upper) || (~|upper);
        if (in_range) begin
            data = shifted[OUT_W-1:0];
            sat  = 1'b0;
        end else begin
            data = shifted[ACC_W] ? SAT_MIN : SAT_MAX;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/myproject_dense_accum.sv
// Dense-layer output accumulator.
// Sums N_IN signed products per neuron plus the neuron bias, rounds and
// saturates to the activation format and hands the result downstream over a
// valid/ready handshake. One frame is in flight at a time.
// Ports:
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   in_valid/in_ready       input beat handshake
//   in_prod                 signed product (PROD_W)
//   in_last                 producer's end-of-frame flag, only checked
//   bias                    signed bias at output scale, taken on beat 0
//   out_valid/out_ready     result handshake
//   out_data, out_sat       result and its saturation flag
//   err_len                 sticky in_last / beat-count disagreement
module myproject_dense_accum #(
    parameter int PROD_W     = myproject_accum_pkg::PROD_W,
    parameter int N_IN       = 16,
    parameter int ACC_W      = myproject_accum_pkg::ACC_W,
    parameter int OUT_W      = myproject_accum_pkg::OUT_W,
    parameter int FRAC_SHIFT = myproject_accum_pkg::FRAC_SHIFT
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic [OUT_W-1:0]  bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              err_len
);

    import myproject_accum_pkg::*;

    localparam int CNT_W = (N_IN > 2) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               out_valid_reg;
    logic [OUT_W-1:0]   out_data_reg;
    logic               out_sat_reg;
    logic               err_len_reg;

    logic               beat;
    logic               last_beat;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   bias_ext;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   sum_next;
    logic [OUT_W-1:0]   rs_data;
    logic               rs_sat;

    // Ready follows the state directly so the first cycle after reset can
    // already accept a beat; held low while reset is asserted.
    assign in_ready  = (state_reg == ACCUM) && !ap_rst;
    assign beat      = in_valid && in_ready;
    assign last_beat = (cnt_reg == CNT_LAST);

    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
        // Bias lives at output scale; move it up to product scale.
        bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias} << FRAC_SHIFT;
        // Beat 0 starts a fresh sum from the bias, which drops any leftover
        // accumulator contents from the previous frame.
        acc_base = (cnt_reg == '0) ? bias_ext : acc_reg;
        sum_next = acc_base + prod_ext;
    end

    myproject_round_sat #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .sum  (sum_next),
        .data (rs_data),
        .sat  (rs_sat)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg     <= ACCUM;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            err_len_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (beat) begin
                        acc_reg <= sum_next;
                        // Frame boundaries come from the counter; in_last is
                        // only compared against it.
                        if (in_last != last_beat) begin
                            err_len_reg <= 1'b1;
                        end
                        if (last_beat) begin
                            cnt_reg       <= '0;
                            out_data_reg  <= rs_data;
                            out_sat_reg   <= rs_sat;
                            out_valid_reg <= 1'b1;
                            state_reg     <= OUT;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ACCUM;
                    end
                end
                default: begin
                    state_reg <= ACCUM;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign err_len   = err_len_reg;

endmodule

// File: tb/tb_myproject_dense_accum.sv
// Directed bench for myproject_dense_accum with a 4-beat frame.
module tb_myproject_dense_accum;

    localparam int PROD_W = 28;
    localparam int OUT_W  = 16;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic [OUT_W-1:0]  bias;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              err_len;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    myproject_dense_accum #(
        .PROD_W     (28),
        .N_IN       (4),
        .ACC_W      (34),
        .OUT_W      (16),
        .FRAC_SHIFT (10)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .err_len   (err_len)
    );

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // Presents one beat for exactly one clock edge.
    task automatic beat(input int p, input int b, input logic l);
        in_valid = 1'b1;
        in_prod  = PROD_W'(p);
        bias     = OUT_W'(b);
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = '0;
    endtask

    task automatic send_frame(input int p0, input int p1, input int p2, input int p3, input int b);
        beat(p0, b, 1'b0);
        beat(p1, 0, 1'b0);
        beat(p2, 0, 1'b0);
        beat(p3, 0, 1'b1);
    endtask

    task automatic test_reset;
        ap_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        checks++;
        if ({out_valid, out_sat, err_len, out_data} !== {3'b000, 16'd0}) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b sat=%b err=%b data=%0d want all 0",
                     out_valid, out_sat, err_len, out_data);
        end
        ap_rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got %b want 1", in_ready);
        end
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        beat(1024, 0, 1'b0);
        beat(1024, 0, 1'b0);
        beat(1024, 0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b want 0", out_valid);
        end
        beat(1024, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd4 || out_sat !== 1'b0 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got valid=%b data=%0d sat=%b err=%b want 1 4 0 0",
                     out_valid, $signed(out_data), out_sat, err_len);
        end
        $display("basic frame: data=%0d sat=%b", $signed(out_data), out_sat);
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_bias_round;
        send_frame(512, 0, 0, 0, 3);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd4 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL bias_round_pos got valid=%b data=%0d sat=%b want 1 4 0",
                     out_valid, $signed(out_data), out_sat);
        end
        $display("bias+round frame: data=%0d sat=%b", $signed(out_data), out_sat);
        tick();
        send_frame(-512, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL bias_round_half got valid=%b data=%0d sat=%b want 1 0 0",
                     out_valid, $signed(out_data), out_sat);
        end
        $display("half-up frame: data=%0d sat=%b", $signed(out_data), out_sat);
        tick();
    endtask

    task automatic test_saturation;
        send_frame(1 << 26, 1 << 26, 1 << 26, 1 << 26, 0);
        checks++;
        if ($signed(out_data) !== 16'sd32767 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got data=%0d sat=%b want 32767 1", $signed(out_data), out_sat);
        end
        $display("sat+ frame: data=%0d sat=%b", $signed(out_data), out_sat);
        tick();
        send_frame(-(1 << 26), -(1 << 26), -(1 << 26), -(1 << 26), 0);
        checks++;
        if ($signed(out_data) !== -16'sd32768 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg got data=%0d sat=%b want -32768 1", $signed(out_data), out_sat);
        end
        $display("sat- frame: data=%0d sat=%b", $signed(out_data), out_sat);
        tick();
    endtask

    task automatic test_back_to_back;
        int bad;
        out_ready = 1'b0;
        // bias 1 -> 1024, products 4*2048 -> 9216, rounds to 9
        send_frame(2048, 2048, 2048, 2048, 1);
        bad = 0;
        // Beats offered while the result is held must be ignored.
        in_valid = 1'b1;
        in_prod  = PROD_W'(1 << 26);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd9 || in_ready !== 1'b0) bad++;
            tick();
        end
        in_valid = 1'b0;
        in_prod  = '0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold got %0d bad cycles (valid=%b data=%0d in_ready=%b) want 0",
                     bad, out_valid, $signed(out_data), in_ready);
        end
        $display("backpressure frame: data=%0d held 5 cycles", $signed(out_data));
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        // bias 5 -> 5120, products sum 2048 -> 7168, rounds to 7
        send_frame(1024, -2048, 3072, 0, 5);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd7 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back got valid=%b data=%0d sat=%b want 1 7 0",
                     out_valid, $signed(out_data), out_sat);
        end
        $display("back-to-back frame: data=%0d sat=%b", $signed(out_data), out_sat);
        tick();
    endtask

    task automatic test_len_err;
        beat(1024, 0, 1'b0);
        checks++;
        if (err_len !== 1'b0) begin
            errors++;
            $display("FAIL len_err_early got %b want 0", err_len);
        end
        beat(1024, 0, 1'b1);
        checks++;
        if (err_len !== 1'b1) begin
            errors++;
            $display("FAIL len_err_set got %b want 1", err_len);
        end
        beat(1024, 0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL len_err_boundary got valid=%b want 0", out_valid);
        end
        beat(1024, 0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd4 || err_len !== 1'b1) begin
            errors++;
            $display("FAIL len_err_frame got valid=%b data=%0d err=%b want 1 4 1",
                     out_valid, $signed(out_data), err_len);
        end
        $display("length-error frame: data=%0d err_len=%b", $signed(out_data), err_len);
        tick();
        tick();
        checks++;
        if (err_len !== 1'b1) begin
            errors++;
            $display("FAIL len_err_sticky got %b want 1", err_len);
        end
    endtask

    task automatic test_reset_midframe;
        beat(1024, 0, 1'b0);
        beat(1024, 0, 1'b0);
        ap_rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || err_len !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got valid=%b err=%b in_ready=%b want 0 0 0",
                     out_valid, err_len, in_ready);
        end
        ap_rst = 1'b0;
        send_frame(1024, 1024, 1024, 1024, 0);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd4 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL midframe_result got valid=%b data=%0d err=%b want 1 4 0",
                     out_valid, $signed(out_data), err_len);
        end
        $display("post-reset frame: data=%0d err_len=%b", $signed(out_data), err_len);
        tick();
    endtask

    initial begin
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_bias_round();
        test_saturation();
        test_back_to_back();
        test_len_err();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
